// File: rtl/pipe_cpu_pkg.sv
// Shared pipeline CPU definitions: ALU control codes and mul/div FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_cpu_pkg;

   // AluControl codes for the iterative mul/div unit
   localparam logic [3:0] ALU_DIV   = 4'b1000;
   localparam logic [3:0] ALU_DIVU  = 4'b1001;
   localparam logic [3:0] ALU_MULT  = 4'b1010;
   localparam logic [3:0] ALU_MULTU = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } muldiv_state_t;

   // The four mul/div codes share the 10xx prefix
   function automatic logic is_muldiv_op(input logic [3:0] op);
      return (op[3:2] == 2'b10);
   endfunction

   function automatic logic is_signed_op(input logic [3:0] op);
      return (op == ALU_DIV) || (op == ALU_MULT);
   endfunction

endpackage

// File: rtl/pipe_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a 2W accumulator.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module pipe_muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   opd_i,
   input  logic               is_div_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] rem_sub;
   logic             rem_ge;

   // Multiply: {partial, multiplier} adds the multiplicand on LSB then shifts right.
   // Divide:   {remainder, dividend} shifts left and keeps the subtract if it fits.
   always_comb begin
      mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opd_i} : '0);
      rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      rem_ge  = (rem_sh >= {1'b0, opd_i});
      rem_sub = rem_sh[WIDTH-1:0] - opd_i;
      if (is_div_i) begin
         acc_o = rem_ge ? {rem_sub, acc_i[WIDTH-2:0], 1'b1}
                        : {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
         acc_o = {mul_sum, acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/pipe_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one result bit per cycle.
// Latency: done WIDTH+1 edges after the start edge; divide-by-zero done 1 edge after it.
// Backpressure: busy stalls the pipeline; start/MTHI/MTLO are ignored while busy, flush aborts.
module pipe_muldiv_unit
   import pipe_cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   muldiv_state_t      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opd_q, opd_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;          // quotient/product sign
   logic               neg_rem_q, neg_rem_d;  // remainder follows dividend
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, dzo_q, dzo_d;

   logic               a_neg, b_neg, op_is_div;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [2*WIDTH-1:0] step_acc, prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign op_is_div = ~op[1];
   assign a_neg     = is_signed_op(op) & operand_a[WIDTH-1];
   assign b_neg     = is_signed_op(op) & operand_b[WIDTH-1];
   // Most-negative input maps to itself, which is the right unsigned magnitude
   assign a_abs     = a_neg ? -operand_a : operand_a;
   assign b_abs     = b_neg ? -operand_b : operand_b;

   assign prod_fix  = neg_q ? -acc_q : acc_q;
   assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   pipe_muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc_i    (acc_q),
      .opd_i    (opd_q),
      .is_div_i (is_div_q),
      .acc_o    (step_acc)
   );

   // Next-state: accept in IDLE, iterate in RUN, sign-fix and commit in FIX
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opd_d     = opd_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dzo_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (mthi) hi_d = wdata;
            if (mtlo) lo_d = wdata;
            if (start && !flush && is_muldiv_op(op)) begin
               is_div_d  = op_is_div;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               cnt_d     = CNT_W'(WIDTH);
               if (op_is_div && (operand_b == '0)) begin
                  // Result is preloaded; FIX commits it without sign handling
                  dz_d    = 1'b1;
                  acc_d   = {operand_a, {WIDTH{1'b1}}};
                  state_d = FIX;
               end else begin
                  dz_d    = 1'b0;
                  acc_d   = {{WIDTH{1'b0}}, (op_is_div ? a_abs : b_abs)};
                  opd_d   = op_is_div ? b_abs : a_abs;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               acc_d = step_acc;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush) begin
               done_d = 1'b1;
               dzo_d  = dz_q;
               if (dz_q)          {hi_d, lo_d} = acc_q;
               else if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else           {hi_d, lo_d} = prod_fix;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opd_q     <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dzo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opd_q     <= opd_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dzo_q     <= dzo_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = dzo_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipe_muldiv_unit;
   import pipe_cpu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0, reset_n = 1'b1;
   logic         start = 1'b0, mthi = 1'b0, mtlo = 1'b0, flush = 1'b0;
   logic [3:0]   op = 4'd0;
   logic [W-1:0] operand_a = '0, operand_b = '0, wdata = '0;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   pipe_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result of one operation, from plain integer arithmetic
   task automatic calc(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
      longint     sp;
      logic [63:0] up;
      int         sa, sb;
      dz = 1'b0;
      h  = '0;
      l  = '0;
      sa = $signed(a);
      sb = $signed(b);
      case (o)
         ALU_MULT: begin
            sp = longint'(sa) * longint'(sb);
            up = sp;
            h  = up[63:32];
            l  = up[31:0];
         end
         ALU_MULTU: begin
            up = 64'(a) * 64'(b);
            h  = up[63:32];
            l  = up[31:0];
         end
         ALU_DIV: begin
            if (b == 0) begin
               dz = 1'b1; h = a; l = '1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               l = 32'h8000_0000; h = '0;
            end else begin
               l = sa / sb;
               h = sa % sb;
            end
         end
         default: begin
            if (b == 0) begin
               dz = 1'b1; h = a; l = '1;
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endtask

   // Reference model: an accepted op commits at a fixed edge deadline unless flushed
   logic [W-1:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
   logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, r_dz = 1'b0;
   bit           inflight = 1'b0;
   int           cyc = 0, done_at = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
         inflight = 1'b0;
      end else begin
         cyc++;
         m_done = 1'b0;
         m_dz   = 1'b0;
         if (inflight) begin
            if (flush) inflight = 1'b0;
            else if (cyc == done_at) begin
               m_hi = r_hi; m_lo = r_lo; m_done = 1'b1; m_dz = r_dz;
               inflight = 1'b0;
            end
         end else begin
            if (mthi) m_hi = wdata;
            if (mtlo) m_lo = wdata;
            if (start && !flush && op >= 4'd8 && op <= 4'd11) begin
               calc(op, operand_a, operand_b, r_hi, r_lo, r_dz);
               inflight = 1'b1;
               done_at  = cyc + (r_dz ? 1 : W + 1);
            end
         end
         m_busy = inflight;
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
   end

   // Slot n is the n-th falling edge after the start edge (slot 1 = first busy cycle)
   task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int poke, output int lat, output int bcnt, output logic dzd);
      logic [W-1:0] lo_seen;
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      lat = 0; bcnt = 0; dzd = 1'b0; lo_seen = '0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         start = 1'b0;
         mtlo  = 1'b0;
         if (poke > 0 && n == poke + 1) chk("lo held under busy mtlo", 64'(lo), 64'(lo_seen));
         if (busy) bcnt++;
         if (done) begin
            lat = n;
            dzd = div_zero;
            break;
         end
         if (n == poke) begin
            lo_seen = lo;
            start = 1'b1; op = ALU_DIVU; operand_b = 32'd1;
            mtlo = 1'b1; wdata = 32'hDEAD_0000;
         end
      end
      chk("op completes within bound", 64'(lat > 0), 64'd1);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom());
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, bcnt, seen;
      logic dzd;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      reset_n = 1'b1;

      run_op(ALU_MULT, 32'hFFFF_FFFE, 32'd3, 0, lat, bcnt, dzd);
      chk("mult latency slot", 64'(lat), 64'd34);
      chk("mult busy cycles", 64'(bcnt), 64'd33);
      chk("mult hi", 64'(hi), 64'hFFFF_FFFF);
      chk("mult lo", 64'(lo), 64'hFFFF_FFFA);

      run_op(ALU_MULTU, 32'hFFFF_FFFE, 32'd3, 0, lat, bcnt, dzd);
      chk("multu hi", 64'(hi), 64'h0000_0002);
      chk("multu lo", 64'(lo), 64'hFFFF_FFFA);

      run_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, bcnt, dzd);
      chk("div -7/2 lo", 64'(lo), 64'hFFFF_FFFD);
      chk("div -7/2 hi", 64'(hi), 64'hFFFF_FFFF);

      run_op(ALU_DIVU, 32'd100, 32'd7, 0, lat, bcnt, dzd);
      chk("divu 100/7 lo", 64'(lo), 64'd14);
      chk("divu 100/7 hi", 64'(hi), 64'd2);

      run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcnt, dzd);
      chk("div ovf lo", 64'(lo), 64'h8000_0000);
      chk("div ovf hi", 64'(hi), 64'd0);

      run_op(ALU_DIVU, 32'd7, 32'd0, 0, lat, bcnt, dzd);
      chk("div0 latency slot", 64'(lat), 64'd2);
      chk("div0 flag", 64'(dzd), 64'd1);
      chk("div0 hi", 64'(hi), 64'd7);
      chk("div0 lo", 64'(lo), 64'hFFFF_FFFF);

      // Second start and MTLO during busy must not disturb the running MULT
      run_op(ALU_MULT, 32'd6, 32'd7, 5, lat, bcnt, dzd);
      chk("mult under poke lo", 64'(lo), 64'd42);
      chk("mult under poke hi", 64'(hi), 64'd0);

      @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
      @(negedge clk); mthi = 1'b0;
      chk("mthi idle", 64'(hi), 64'h1234);

      @(negedge clk); start = 1'b1; op = 4'b0010;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); start = 1'b0;
         if (busy) seen++;
      end
      chk("invalid op no busy", 64'(seen), 64'd0);

      // Flush mid-operation keeps HI/LO and produces no done
      @(negedge clk); mthi = 1'b1; wdata = 32'h1111;
      @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h2222;
      @(negedge clk); mtlo = 1'b0; start = 1'b1; op = ALU_MULT; operand_a = 5; operand_b = 5;
      repeat (10) begin
         @(negedge clk); start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("flush busy", 64'(busy), 64'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) seen++;
         @(negedge clk);
      end
      chk("flush no done", 64'(seen), 64'd0);
      chk("flush hi", 64'(hi), 64'h1111);
      chk("flush lo", 64'(lo), 64'h2222);

      // Asynchronous reset mid-operation clears everything at once
      start = 1'b1; op = ALU_MULT;
      repeat (10) begin
         @(negedge clk); start = 1'b0;
      end
      #2 reset_n = 1'b0;
      #1;
      chk("arst busy", 64'(busy), 64'd0);
      chk("arst done", 64'(done), 64'd0);
      chk("arst hi", 64'(hi), 64'd0);
      chk("arst lo", 64'(lo), 64'd0);
      @(negedge clk); reset_n = 1'b1;

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start     = ($urandom_range(0, 3) == 0);
         op        = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'(8 + $urandom_range(0, 3));
         operand_a = pick();
         operand_b = pick();
         mthi      = ($urandom_range(0, 7) == 0);
         mtlo      = ($urandom_range(0, 7) == 0);
         wdata     = 32'($urandom());
         flush     = ($urandom_range(0, 255) == 0);
      end
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
      for (int i = 0; i < 60 && busy; i++) @(negedge clk);
      chk("drain idle", 64'(busy), 64'd0);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
